pipelined_adder_tree: RTL and testbench
=======================================

# pipelined_adder_tree

Fully pipelined, parametrised adder tree that sums `NUM_INPUT` signed or unsigned words per beat. A valid bit travels alongside the data, and a global `ena` stalls the whole pipeline. An optional accumulate mode sums consecutive beats into frames delimited by `din_last`, with an overflow flag. It sits in DSP datapaths (FIR tap sums, correlators, block energy) where the single-cycle adder tree cannot meet timing for wide or deep inputs.

## Interface
- `NUM_INPUT`, 8: number of input words per beat, ≥1.
- `WIDTH_IN`, 16: input word width, >0.
- `IS_SIGNED`, 1: 1 = sign-extend inputs, 0 = zero-extend.
- `ACCUMULATE`, 0: 0 = one output per beat; 1 = one output per frame.
- `ACC_LEN_MAX`, 16: maximum beats per frame without overflow, ≥2; used only when `ACCUMULATE`=1.
- `L` (derived): max(1, $clog2(NUM_INPUT)), the number of tree levels.
- `WIDTH_SUM` (derived): WIDTH_IN + $clog2(NUM_INPUT).
- `WIDTH_OUT` (derived): WIDTH_SUM when ACCUMULATE=0; WIDTH_SUM + $clog2(ACC_LEN_MAX) when ACCUMULATE=1.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `ena` in 1: pipeline advance; 0 freezes every register.
- `din_valid` in 1: beat present on `din`.
- `din` in [WIDTH_IN-1:0] x NUM_INPUT: unpacked array of input words.
- `din_last` in 1: last beat of frame; ignored when ACCUMULATE=0.
- `dout` out WIDTH_OUT: sum.
- `dout_valid` out 1: `dout` is valid this cycle.
- `dout_ovf` out 1: frame exceeded ACC_LEN_MAX beats; always 0 when ACCUMULATE=0.

## Operation
- **Beat acceptance:** a beat is accepted at a rising edge with `ena`=1 and `din_valid`=1.
- **Stage 0:** each word is extended to WIDTH_SUM, by sign or zero per IS_SIGNED.
- **Tree levels:** level k (1..L) adds adjacent pairs of level k-1. An odd trailing item passes unchanged. Every level is registered together with its valid bit and last bit.
- **NUM_INPUT=1:** a single register stage (L=1) holding the extended word.
- **Tree arithmetic:** the tree sum is exact, with no overflow possible within WIDTH_SUM.
- **ACCUMULATE=0:** `dout` is the level-L register, zero-extended or sign-extended as appropriate. `dout_valid` is the level-L valid bit.
- **ACCUMULATE=1:** one accumulator stage follows level L. It holds `acc` (WIDTH_OUT bits), a start flag `first` (reset to 1), and a beat counter `cnt` that saturates at ACC_LEN_MAX+1.
  - On a valid level-L beat with `ena`=1: `sum` = (first ? 0 : acc) + ext(tree). `cnt` becomes (first ? 1 : cnt+1).
  - If that beat's last bit is 0: `acc` ← sum, `first` ← 0, `dout_valid` ← 0.
  - If that beat's last bit is 1: `dout` ← sum, `dout_valid` ← 1, `dout_ovf` ← (new cnt > ACC_LEN_MAX), `first` ← 1.
  - A single-beat frame (`first` and last together) outputs the tree sum directly.
  - On overflow the sum wraps modulo 2^WIDTH_OUT. `dout_ovf` is reported with that frame only.
- **Stall (`ena`=0):** every register holds, including `dout`, `dout_valid`, `dout_ovf`, `acc`, `cnt` and `first`. `din` and `din_valid` are ignored. The consumer samples the output only when `dout_valid` && `ena`.
- **Empty beats:** a cycle with `ena`=1 and `din_valid`=0 injects a bubble. Bubbles never touch the accumulator and never produce output.
- **Reset:** `rst_n`=0 at any time, including mid-frame or mid-pipeline, asynchronously clears:
  - all valid bits and last bits;
  - `dout`=0, `dout_valid`=0, `dout_ovf`=0;
  - `acc`=0, `cnt`=0, `first`=1.
  
  In-flight beats are discarded.

## Timing
- **Throughput:** one beat per cycle while `ena`=1; no backpressure output.
- **ACCUMULATE=0 latency:** a beat accepted at edge n appears with `dout_valid`=1 after edge n+L-1. That is L cycles from acceptance, counting only edges with `ena`=1.
- **ACCUMULATE=1 latency:** a frame whose last beat is accepted at edge n gives `dout_valid`=1 after edge n+L, i.e. L+1 enabled edges.
- **Output pulse:** `dout_valid` asserts for exactly one enabled cycle per output.
- **Back-to-back frames:** a new frame may start on the beat immediately after a last beat, with no gap cycle.
- **Asynchronous reset:** outputs go to reset values immediately on `rst_n` falling. The first beat may be accepted at the first edge after `rst_n` rises.

## Test plan
- **Signed tree, per-beat mode:** NUM_INPUT=8, WIDTH_IN=16, IS_SIGNED=1, ACCUMULATE=0; all inputs 16'h8000 → `dout`=19'h40000 (-262144) after 3 cycles. Then all 16'h7FFF → 262136.
- **Unsigned, odd count, streaming:** NUM_INPUT=5, IS_SIGNED=0, all 16'hFFFF → `dout`=327675, L=3. Back-to-back beats with values 1..10 give outputs in order, one per cycle.
- **Stall insertion:** toggle `ena` low for 2 cycles mid-stream. Required: no lost or duplicated outputs, and output order preserved.
- **Accumulate, normal frame:** ACCUMULATE=1, ACC_LEN_MAX=4, NUM_INPUT=4, all inputs 1. A 4-beat frame → `dout`=16, `dout_ovf`=0, 3 cycles after the last beat. Immediately follow with a 1-beat frame → `dout`=4.
- **Accumulate, overflow:** a 5-beat frame with ACC_LEN_MAX=4 → `dout_ovf`=1 on that output. The next frame reports `dout_ovf`=0.
- **Reset mid-frame:** assert `rst_n` low during beat 2 of a frame. Required: `dout_valid`=0 and `dout`=0 immediately, and the next frame's result excludes the pre-reset beats.

Source files
------------

// File: rtl/pipelined_adder_tree_if.sv
// pipelined_adder_tree_if: beat input and sum output bundle for the adder tree
interface pipelined_adder_tree_if #(
  parameter int NUM_INPUT = 8,
  parameter int WIDTH_IN  = 16,
  parameter int WIDTH_OUT = 19
);
  logic                 ena;
  logic                 din_valid;
  logic                 din_last;
  logic [WIDTH_IN-1:0]  din [NUM_INPUT];
  logic [WIDTH_OUT-1:0] dout;
  logic                 dout_valid;
  logic                 dout_ovf;
  modport master (output ena, din_valid, din_last, din, input dout, dout_valid, dout_ovf);
  modport slave  (input ena, din_valid, din_last, din, output dout, dout_valid, dout_ovf);
endinterface

// File: rtl/pipelined_adder_tree.sv
// pipelined_adder_tree: registered pairwise adder tree with optional frame accumulator
module pipelined_adder_tree #(
  parameter int NUM_INPUT   = 8,
  parameter int WIDTH_IN    = 16,
  parameter int IS_SIGNED   = 1,
  parameter int ACCUMULATE  = 0,
  parameter int ACC_LEN_MAX = 16
) (
  input logic clk,
  input logic rst_n,
  pipelined_adder_tree_if.slave s
);
  localparam int L         = NUM_INPUT > 1 ? $clog2(NUM_INPUT) : 1;
  localparam int WIDTH_SUM = WIDTH_IN + $clog2(NUM_INPUT);
  localparam int WIDTH_OUT = ACCUMULATE != 0 ? WIDTH_SUM + $clog2(ACC_LEN_MAX) : WIDTH_SUM;

  function automatic int lvl_n(input int k);
    int n = NUM_INPUT;
    for (int i = 0; i < k; i++) n = (n + 1) / 2;
    return n;
  endfunction

  logic [WIDTH_SUM-1:0] w_src [1:L][NUM_INPUT];
  logic [WIDTH_SUM-1:0] w_nxt [1:L][NUM_INPUT];
  logic [WIDTH_SUM-1:0] r_lvl [1:L][NUM_INPUT];
  logic [L-1:0]         r_vld;

  genvar k, j;
  generate
    for (k = 1; k <= L; k++) begin : g_lvl
      for (j = 0; j < NUM_INPUT; j++) begin : g_item
        if (k == 1) begin : g_ext
          assign w_src[k][j] = IS_SIGNED != 0 ? WIDTH_SUM'($signed(s.din[j])) : WIDTH_SUM'(s.din[j]);
        end else begin : g_prev
          assign w_src[k][j] = r_lvl[k-1][j];
        end
        // slots past this level's item count stay zero; an odd trailing item passes through
        if (j >= lvl_n(k)) begin : g_idle
          assign w_nxt[k][j] = '0;
        end else if (2 * j + 1 < lvl_n(k - 1)) begin : g_add
          assign w_nxt[k][j] = w_src[k][2*j] + w_src[k][2*j+1];
        end else begin : g_pass
          assign w_nxt[k][j] = w_src[k][2*j];
        end
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) r_lvl[k][j] <= '0;
          else if (s.ena) r_lvl[k][j] <= w_nxt[k][j];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_vld <= '0;
    else if (s.ena) r_vld <= L'({r_vld, s.din_valid});

  generate
    if (ACCUMULATE == 0) begin : g_beat
      assign s.dout       = r_lvl[L][0];
      assign s.dout_valid = r_vld[L-1];
      assign s.dout_ovf   = 1'b0;
    end else begin : g_acc
      localparam int CW = $clog2(ACC_LEN_MAX + 2);
      logic [L-1:0]         r_lst;
      logic [WIDTH_OUT-1:0] r_acc, r_dout, w_tx, w_sum;
      logic [CW-1:0]        r_cnt, w_cnt;
      logic                 r_first, r_dv, r_ovf;
      assign w_tx  = IS_SIGNED != 0 ? WIDTH_OUT'($signed(r_lvl[L][0])) : WIDTH_OUT'(r_lvl[L][0]);
      assign w_sum = (r_first ? '0 : r_acc) + w_tx;
      // beat count saturates one past the limit so overflow stays visible for long frames
      assign w_cnt = r_first ? CW'(1) : (r_cnt == CW'(ACC_LEN_MAX + 1) ? r_cnt : r_cnt + CW'(1));
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_lst <= '0;
        else if (s.ena) r_lst <= L'({r_lst, s.din_last});
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          r_acc   <= '0;
          r_cnt   <= '0;
          r_first <= 1'b1;
          r_dout  <= '0;
          r_dv    <= 1'b0;
          r_ovf   <= 1'b0;
        end else if (s.ena) begin
          r_dv <= r_vld[L-1] & r_lst[L-1];
          if (r_vld[L-1]) begin
            r_cnt   <= w_cnt;
            r_first <= r_lst[L-1];
            if (r_lst[L-1]) begin
              r_dout <= w_sum;
              r_ovf  <= w_cnt > CW'(ACC_LEN_MAX);
            end else r_acc <= w_sum;
          end
        end
      assign s.dout       = r_dout;
      assign s.dout_valid = r_dv;
      assign s.dout_ovf   = r_ovf;
    end
  endgenerate
endmodule

// File: tb/tb_pipelined_adder_tree.sv
// tb_pipelined_adder_tree: scoreboard bench over signed, odd-unsigned and accumulating trees
module tb_pipelined_adder_tree;
  localparam int LA = 3, LB = 3, LC = 2;
  typedef struct { logic [19:0] d; logic o; int due; } exp_t;

  logic clk = 0, rst_n = 0, ena = 0;
  int   checks = 0, errs = 0, edges = 0;
  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;

  always #5 clk = ~clk;
  always @(posedge clk) if (ena) edges++;

  pipelined_adder_tree_if #(.NUM_INPUT(8), .WIDTH_IN(16), .WIDTH_OUT(19)) ia();
  pipelined_adder_tree_if #(.NUM_INPUT(5), .WIDTH_IN(16), .WIDTH_OUT(19)) ib();
  pipelined_adder_tree_if #(.NUM_INPUT(4), .WIDTH_IN(16), .WIDTH_OUT(20)) ic();
  assign ia.ena = ena;
  assign ib.ena = ena;
  assign ic.ena = ena;

  pipelined_adder_tree #(.NUM_INPUT(8), .WIDTH_IN(16), .IS_SIGNED(1), .ACCUMULATE(0), .ACC_LEN_MAX(16))
    ua (.clk(clk), .rst_n(rst_n), .s(ia));
  pipelined_adder_tree #(.NUM_INPUT(5), .WIDTH_IN(16), .IS_SIGNED(0), .ACCUMULATE(0), .ACC_LEN_MAX(16))
    ub (.clk(clk), .rst_n(rst_n), .s(ib));
  pipelined_adder_tree #(.NUM_INPUT(4), .WIDTH_IN(16), .IS_SIGNED(0), .ACCUMULATE(1), .ACC_LEN_MAX(4))
    uc (.clk(clk), .rst_n(rst_n), .s(ic));

  always @(negedge clk) if (rst_n && ena && ia.dout_valid) begin
    checks++;
    if (qa.size() == 0) begin
      errs++;
      $display("FAIL a_extra dout=%0h", ia.dout);
    end else begin
      ea = qa.pop_front();
      if (ia.dout !== ea.d[18:0] || edges != ea.due) begin
        errs++;
        $display("FAIL a_out dout=%0h edge=%0d required dout=%0h edge=%0d", ia.dout, edges, ea.d[18:0], ea.due);
      end
    end
  end

  always @(negedge clk) if (rst_n && ena && ib.dout_valid) begin
    checks++;
    if (qb.size() == 0) begin
      errs++;
      $display("FAIL b_extra dout=%0d", ib.dout);
    end else begin
      eb = qb.pop_front();
      if (ib.dout !== eb.d[18:0] || edges != eb.due) begin
        errs++;
        $display("FAIL b_out dout=%0d edge=%0d required dout=%0d edge=%0d", ib.dout, edges, eb.d[18:0], eb.due);
      end
    end
  end

  always @(negedge clk) if (rst_n && ena && ic.dout_valid) begin
    checks++;
    if (qc.size() == 0) begin
      errs++;
      $display("FAIL c_extra dout=%0d ovf=%0b", ic.dout, ic.dout_ovf);
    end else begin
      ec = qc.pop_front();
      if (ic.dout !== ec.d || ic.dout_ovf !== ec.o || edges != ec.due) begin
        errs++;
        $display("FAIL c_out dout=%0d ovf=%0b edge=%0d required dout=%0d ovf=%0b edge=%0d",
                 ic.dout, ic.dout_ovf, edges, ec.d, ec.o, ec.due);
      end
    end
  end

  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s got=%0h required=%0h", n, got, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ena = 1;
      ia.din_valid = 0; ib.din_valid = 0; ic.din_valid = 0; ic.din_last = 0;
    end
  endtask

  task automatic stall(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      ena = 0;
      ia.din_valid = 0; ib.din_valid = 0; ic.din_valid = 0;
    end
  endtask

  task automatic send_a(input logic [15:0] w [8], input logic [19:0] v);
    @(posedge clk); #1;
    ena = 1; ia.din = w; ia.din_valid = 1; ib.din_valid = 0; ic.din_valid = 0;
    qa.push_back('{d: v, o: 1'b0, due: edges + LA});
  endtask

  task automatic send_b(input logic [15:0] w [5], input logic [19:0] v);
    @(posedge clk); #1;
    ena = 1; ib.din = w; ib.din_valid = 1; ia.din_valid = 0; ic.din_valid = 0;
    qb.push_back('{d: v, o: 1'b0, due: edges + LB});
  endtask

  task automatic send_c(input logic [15:0] w [4], input logic last, input logic [19:0] v, input logic o);
    @(posedge clk); #1;
    ena = 1; ic.din = w; ic.din_valid = 1; ic.din_last = last; ia.din_valid = 0; ib.din_valid = 0;
    if (last) qc.push_back('{d: v, o: o, due: edges + LC + 1});
  endtask

  task automatic frame_c(input int beats, input logic [15:0] x, input logic [19:0] v, input logic o);
    for (int i = 1; i <= beats; i++) send_c('{x, x, x, x}, i == beats, v, o);
  endtask

  task automatic drain();
    int i;
    idle(1);
    for (i = 0; i < 40 && (qa.size() + qb.size() + qc.size()) != 0; i++) idle(1);
    chk("drain_pending", qa.size() + qb.size() + qc.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    ia.din = '{default: '0}; ib.din = '{default: '0}; ic.din = '{default: '0};
    ia.din_valid = 0; ib.din_valid = 0; ic.din_valid = 0;
    ia.din_last = 0; ib.din_last = 0; ic.din_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_a_dout", ia.dout, 0);
    chk("rst_a_valid", ia.dout_valid, 0);
    chk("rst_b_dout", ib.dout, 0);
    chk("rst_b_valid", ib.dout_valid, 0);
    chk("rst_c_dout", ic.dout, 0);
    chk("rst_c_valid", ic.dout_valid, 0);
    chk("rst_c_ovf", ic.dout_ovf, 0);
    rst_n = 1;
    ena = 1;

    send_a('{8{16'h8000}}, 20'h40000);
    send_a('{8{16'h7FFF}}, 20'h3FFF8);
    send_a('{16'h0001, 16'hFFFF, 16'h0002, 16'hFFFE, 16'h0003, 16'hFFFD, 16'h0064, 16'hFFCE}, 20'h00032);
    send_a('{8{16'hFFFF}}, 20'h7FFF8);
    idle(1);

    send_b('{5{16'hFFFF}}, 20'd327675);
    for (int i = 1; i <= 10; i++) begin
      send_b('{5{16'(i)}}, 20'(5 * i));
      if (i == 5) stall(2);
    end
    idle(1);

    frame_c(4, 16'd1, 20'd16, 1'b0);
    frame_c(1, 16'd1, 20'd4, 1'b0);
    frame_c(5, 16'd1, 20'd20, 1'b1);
    frame_c(2, 16'd1, 20'd8, 1'b0);
    send_c('{16'd3, 16'd3, 16'd3, 16'd3}, 1'b0, 20'd0, 1'b0);
    idle(1);
    send_c('{16'd5, 16'd0, 16'd0, 16'd0}, 1'b1, 20'd17, 1'b0);
    drain();

    send_c('{4{16'd1}}, 1'b0, 20'd0, 1'b0);
    @(posedge clk); #1;
    ic.din_valid = 1; ic.din_last = 0;
    #3 rst_n = 0;
    #1;
    chk("midrst_c_valid", ic.dout_valid, 0);
    chk("midrst_c_dout", ic.dout, 0);
    chk("midrst_a_dout", ia.dout, 0);
    chk("midrst_b_dout", ib.dout, 0);
    @(posedge clk); #1;
    ic.din_valid = 0;
    rst_n = 1;
    frame_c(2, 16'd2, 20'd16, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
